// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scanner with double-buffered frames
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int GUARD          = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     LAST_P  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]     GUARD_P = PW'(GUARD);
    localparam logic [IW-1:0]     LAST_I  = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]       presc;
    logic [IW-1:0]       index;
    logic [4*DIGITS-1:0] staging, shadow;
    logic [DIGITS-1:0]   staging_dp, shadow_dp;
    logic                pending;

    logic                boundary;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                zero_above;
    logic [DIGITS-1:0]   sel_act;
    logic [6:0]          seg_act;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign boundary = (presc == LAST_P) && (index == LAST_I);

    // Walk digits from the top down so zero_above tells whether this digit and all above are zero.
    always_comb begin
        zero_above = 1'b1;
        cur_nib    = 4'd0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_act    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (shadow[4*k +: 4] == 4'd0);
            if (index == IW'(k)) begin
                cur_nib    = shadow[4*k +: 4];
                cur_dp     = shadow_dp[k];
                cur_blank  = zero_above && (k != 0) && (BLANK_LZ != 0);
                sel_act[k] = (presc >= GUARD_P);
            end
        end
        seg_act = cur_blank ? 7'h00 : decode(cur_nib);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc      <= '0;
            index      <= '0;
            staging    <= '0;
            staging_dp <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            sel        <= SEL_OFF;
        end else begin
            if (presc == LAST_P) begin
                presc <= '0;
                index <= (index == LAST_I) ? '0 : index + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            // A load on the boundary stays pending; the boundary takes the older staging value.
            if (load) begin
                staging    <= bcd_in;
                staging_dp <= dp_in;
                pending    <= 1'b1;
            end else if (boundary) begin
                pending    <= 1'b0;
            end
            if (boundary && pending) begin
                shadow    <= staging;
                shadow_dp <= staging_dp;
            end
            frame_done <= boundary;
            seg        <= seg_act ^ SEG_OFF;
            dp         <= cur_dp ^ DP_OFF;
            sel        <= sel_act ^ SEL_OFF;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. Downstream of the key-press counter: it takes a packed BCD value plus decimal-point mask, double-buffers it so a frame never tears, and scans one digit per slot with an anti-ghosting guard interval. It replaces the single-digit encoder when the count exceeds one digit.

Parameters:
DIGITS, 4, number of digits scanned; legal 1..8.
SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz); must be >= GUARD+2.
GUARD, 16, cycles at the start of each slot during which all digit selects are off.
SEG_ACTIVE_LOW, 1, 1 means a segment is lit when its seg/dp bit is 0.
SEL_ACTIVE_LOW, 1, 1 means a digit is enabled when its sel bit is 0.
BLANK_LZ, 1, 1 enables leading-zero blanking.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
bcd_in  in  4*DIGITS  packed BCD; nibble k is digit k; digit 0 is least significant
dp_in  in  DIGITS  decimal-point request per digit
load  in  1  single-cycle strobe; captures bcd_in/dp_in into the staging register
seg  out  7  segments; bit0=a .. bit6=g
dp  out  1  decimal point of the active digit
sel  out  DIGITS  digit enables; one-hot when active
frame_done  out  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (rst=0, asynchronous): prescaler=0, index=0, staging=0, shadow=0, pending=0. seg, dp and sel all inactive per polarity; frame_done=0. After reset release, the first slot starts at prescaler 0 and index 0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. On wrap, index advances modulo DIGITS.
- Frame boundary is the cycle where prescaler=SCAN_DIV-1 and index=DIGITS-1. On that cycle:
  - frame_done is registered high for exactly the next cycle.
  - If pending=1, shadow <= staging and pending <= 0.
- load=1 behaviour:
  - Sets staging to bcd_in/dp_in and sets pending. If several loads occur in one frame, the last one wins.
  - When load coincides with the boundary cycle, the boundary copies the old staging value. The new value stays pending and is shown next frame.
  - Shadow never changes mid-frame.
- Guard interval: while prescaler < GUARD, sel is all inactive. Otherwise sel is one-hot at index.
- seg/dp are registered from shadow digit[index].
- All outputs are registered; sel/seg/dp reflect the prescaler/index value of the previous cycle (1-cycle latency).
- Decode (active-high pattern gfedcba, inverted when SEG_ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble 10..15 shows "-" (40).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k is blanked (seg all off) if it and every digit above it in shadow are 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - A blanked digit still shows dp when its dp bit is set.
  - Nibbles 10..15 count as nonzero.
- DIGITS=1: index is constant 0; every slot end is a frame boundary.
- Reset asserted mid-frame: immediate return to reset state. Staged and pending data are discarded.

Test Plan:
1. Reset, no load, DIGITS=4, SCAN_DIV=100, GUARD=4 -> after reset, digit 0 only shows "0" (seg=~3F); digits 1..3 show seg all-off; sel off for the first 4 cycles of every slot.
2. load with bcd_in=16'h0107, dp_in=0 -> no change until the next frame_done. The following frame shows 7,0,1 on digits 0,1,2 and digit 3 blanked. Digit 1 shows "0", not blank, because it sits below a nonzero digit.
3. Two loads in one frame (16'h1234, then 16'h5678) -> only 5678 is displayed next frame; 1234 never appears on seg.
4. load on the exact boundary cycle with 16'h0009 -> current frame's successor still shows the old value; 0009 appears one frame later.
5. bcd_in=16'h00A5, dp_in=4'b0100 -> digit1 shows "-" (seg=~40). Digit2 shows blank segments with dp active. frame_done pulses once every 4*SCAN_DIV cycles.
6. Assert rst mid-slot with pending=1 -> outputs go inactive within the same cycle; after release the display shows "0" and the pending value is lost.
